// File: rtl/sb_pkg.sv
// Shared types and byte-lane helpers for the round-robin system bus arbiter.
// Mask helpers work on an 8-lane view; narrower masks are zero-extended by the caller.
package sb_pkg;

    localparam int MAX_LANES = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } sb_state_t;

    function automatic logic [2:0] lane_lo(input logic [MAX_LANES-1:0] mask);
        lane_lo = '0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lane_lo = 3'(i);
            end
        end
    endfunction

    function automatic logic [3:0] lane_cnt(input logic [MAX_LANES-1:0] mask);
        lane_cnt = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            lane_cnt = lane_cnt + 4'(mask[i]);
        end
    endfunction

    // Legal masks are runs of 1/2/4/8 lanes aligned to their own size and inside bm_w.
    function automatic logic mask_legal(input logic [MAX_LANES-1:0] mask, input int bm_w);
        mask_legal = 1'b0;
        for (int s = 1; s <= MAX_LANES; s = s * 2) begin
            for (int off = 0; off < MAX_LANES; off = off + s) begin
                if ((s <= bm_w) && (off + s <= bm_w)) begin
                    if (mask == 8'(((9'd1 << s) - 9'd1) << off)) begin
                        mask_legal = 1'b1;
                    end
                end
            end
        end
    endfunction

endpackage

// File: rtl/sb_lane_fmt.sv
// Byte-lane formatter: aligns write data onto its lanes and right-aligns,
// truncates and extends read data according to the access mask.
module sb_lane_fmt
    import sb_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BM_W = DATA_W / 8
) (
    input  logic [BM_W-1:0]   mask,
    input  logic              un_sign,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [DATA_W-1:0] wdata_al,
    output logic [DATA_W-1:0] rdata_fmt,
    output logic              mask_ok
);

    logic [MAX_LANES-1:0] mask8;
    logic [2:0]           lo;
    logic [3:0]           nb;
    logic [DATA_W-1:0]    rd_sh;
    logic [DATA_W-1:0]    keep;
    logic                 sign;

    always_comb begin
        mask8            = '0;
        mask8[BM_W-1:0]  = mask;
        lo               = lane_lo(mask8);
        nb               = lane_cnt(mask8);
        mask_ok          = mask_legal(mask8, BM_W);

        wdata_al = wdata << {lo, 3'b000};
        rd_sh    = s_rdata >> {lo, 3'b000};

        keep = '0;
        sign = 1'b0;
        for (int b = 0; b < BM_W; b++) begin
            if (b < int'(nb)) begin
                keep[b*8 +: 8] = 8'hFF;
            end
            // Sign bit is the top bit of the last byte inside the access size.
            if (b + 1 == int'(nb)) begin
                sign = rd_sh[b*8 + 7];
            end
        end

        rdata_fmt = rd_sh & keep;
        if (!un_sign && sign) begin
            rdata_fmt = rdata_fmt | ~keep;
        end
        if (!mask_ok) begin
            rdata_fmt = '0;
        end
    end

endmodule

// File: rtl/sb_rr.sv
// N-master round-robin system bus arbiter onto a single synchronous slave port.
//   state  | meaning
//   IDLE   | sample requests, pick round-robin winner, latch its request
//   ACCESS | drive slave strobe/address/lanes from the latched request
//   RESP   | ack winner for one cycle, return formatted read data, advance pointer
module sb_rr
    import sb_pkg::*;
#(
    parameter int N_MST  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int BM_W  = DATA_W / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MST-1:0]        m_re,
    input  logic [N_MST-1:0]        m_we,
    input  logic [N_MST-1:0]        m_un_sign,
    input  logic [N_MST*BM_W-1:0]   m_byte_mask,
    input  logic [N_MST*ADDR_W-1:0] m_addr,
    input  logic [N_MST*DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0]       m_rdata_o,
    output logic [N_MST-1:0]        m_ack_o,
    output logic                    s_en_o,
    output logic                    s_rw_o,
    output logic [ADDR_W-1:0]       s_addr_o,
    output logic [BM_W-1:0]         s_byte_mask_o,
    output logic [DATA_W-1:0]       s_wdata_o,
    input  logic [DATA_W-1:0]       s_rdata
);

    localparam int IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;

    sb_state_t         state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_nxt;
    logic [IDX_W-1:0]  win_q;
    logic              we_q;
    logic              un_sign_q;
    logic [BM_W-1:0]   mask_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [N_MST-1:0]  req;
    logic              gnt_found;
    logic [IDX_W-1:0]  gnt_idx;

    logic [DATA_W-1:0] wdata_al;
    logic [DATA_W-1:0] rdata_fmt;
    logic              mask_ok;

    assign req = m_re | m_we;

    always_comb begin
        int j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_MST; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N_MST) begin
                j = j - N_MST;
            end
            if (!gnt_found && req[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(j);
            end
        end
    end

    assign ptr_nxt = (win_q == IDX_W'(N_MST - 1)) ? '0 : win_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_found) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            we_q      <= 1'b0;
            un_sign_q <= 1'b0;
            mask_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && gnt_found) begin
                win_q     <= gnt_idx;
                // re together with we counts as a write.
                we_q      <= m_we[gnt_idx];
                un_sign_q <= m_un_sign[gnt_idx];
                mask_q    <= m_byte_mask[gnt_idx*BM_W +: BM_W];
                addr_q    <= m_addr[gnt_idx*ADDR_W +: ADDR_W];
                wdata_q   <= m_wdata[gnt_idx*DATA_W +: DATA_W];
            end
            if (state_q == RESP) begin
                ptr_q <= ptr_nxt;
            end
        end
    end

    sb_lane_fmt #(
        .DATA_W (DATA_W)
    ) u_lane_fmt (
        .mask      (mask_q),
        .un_sign   (un_sign_q),
        .wdata     (wdata_q),
        .s_rdata   (s_rdata),
        .wdata_al  (wdata_al),
        .rdata_fmt (rdata_fmt),
        .mask_ok   (mask_ok)
    );

    // Outputs are forced low for the whole reset cycle, not just after the edge.
    always_comb begin
        m_rdata_o     = '0;
        m_ack_o       = '0;
        s_en_o        = 1'b0;
        s_rw_o        = 1'b0;
        s_addr_o      = '0;
        s_byte_mask_o = '0;
        s_wdata_o     = '0;
        if (!rst) begin
            case (state_q)
                ACCESS: begin
                    s_en_o        = mask_ok;
                    s_rw_o        = we_q;
                    s_addr_o      = addr_q;
                    s_byte_mask_o = mask_q;
                    s_wdata_o     = wdata_al;
                end
                RESP: begin
                    m_ack_o[win_q] = 1'b1;
                    if (!we_q) begin
                        m_rdata_o = rdata_fmt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_rr.sv
// Self-checking bench for sb_rr (4 masters, 32-bit data): directed cases plus
// randomized traffic compared against a transaction-level reference model.
module tb_sb_rr;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_re, m_we, m_un_sign;
    logic [N*BW-1:0]   m_byte_mask;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [DW-1:0]     m_rdata_o;
    logic [N-1:0]      m_ack_o;
    logic              s_en_o, s_rw_o;
    logic [AW-1:0]     s_addr_o;
    logic [BW-1:0]     s_byte_mask_o;
    logic [DW-1:0]     s_wdata_o;
    logic [DW-1:0]     s_rdata;

    always #5 clk = ~clk;

    sb_rr #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .m_re          (m_re),
        .m_we          (m_we),
        .m_un_sign     (m_un_sign),
        .m_byte_mask   (m_byte_mask),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_rdata_o     (m_rdata_o),
        .m_ack_o       (m_ack_o),
        .s_en_o        (s_en_o),
        .s_rw_o        (s_rw_o),
        .s_addr_o      (s_addr_o),
        .s_byte_mask_o (s_byte_mask_o),
        .s_wdata_o     (s_wdata_o),
        .s_rdata       (s_rdata)
    );

    // Per-master pending request
    bit          act   [N];
    bit          rq_re [N];
    bit          rq_we [N];
    bit          rq_us [N];
    logic [3:0]  rq_mask  [N];
    logic [31:0] rq_addr  [N];
    logic [31:0] rq_wdata [N];

    int ptr_m = 0;
    int checks = 0;
    int errors = 0;

    logic [N-1:0]  obs_ack;
    logic [31:0]   obs_rd;
    logic          obs_sen, obs_rw;
    logic [3:0]    obs_smask;
    logic [31:0]   obs_swd;
    bit            fix_rd = 1'b0;
    logic [31:0]   fix_val = '0;

    always_comb begin
        m_re = '0; m_we = '0; m_un_sign = '0;
        m_byte_mask = '0; m_addr = '0; m_wdata = '0;
        for (int i = 0; i < N; i++) begin
            m_re[i]              = act[i] & rq_re[i];
            m_we[i]              = act[i] & rq_we[i];
            m_un_sign[i]         = rq_us[i];
            m_byte_mask[i*BW +: BW] = rq_mask[i];
            m_addr[i*AW +: AW]   = rq_addr[i];
            m_wdata[i*DW +: DW]  = rq_wdata[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int low_lane(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic bit legal_m(input logic [3:0] m);
        int n, lo;
        logic [3:0] run;
        n  = $countones(m);
        lo = low_lane(m);
        if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
        if (lo % n != 0) return 1'b0;
        run = 4'(((1 << n) - 1) << lo);
        return m == run;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [3:0] m, input bit us, input logic [31:0] sr);
        logic [63:0] v, keep;
        int n;
        if (!legal_m(m)) return '0;
        n    = $countones(m);
        v    = 64'(sr) >> (8 * low_lane(m));
        keep = (64'd1 << (8 * n)) - 64'd1;
        v    = v & keep;
        if (!us && v[8*n-1]) v = v | ~keep;
        return v[31:0];
    endfunction

    task automatic set_req(input int i, input bit re, input bit we, input bit us,
                           input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd);
        act[i] = 1'b1; rq_re[i] = re; rq_we[i] = we; rq_us[i] = us;
        rq_mask[i] = m; rq_addr[i] = a; rq_wdata[i] = wd;
    endtask

    task automatic rand_req(input int i);
        logic [3:0] legal_set [7];
        int k;
        legal_set = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        k = $urandom_range(0, 2);
        set_req(i, k != 1, k != 0, 1'($urandom),
                ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_set[$urandom_range(0, 6)],
                $urandom, $urandom);
    endtask

    // One arbitration slot starting in IDLE; raise_mid: -1 none, -2 random, else master index.
    task automatic txn(input string tg, input bit reissue, input int raise_mid);
        int w;
        logic [3:0] m;
        logic [31:0] sr;
        bit we, us;
        w = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr_m + k) % N;
            if (w < 0 && act[j] && (rq_re[j] || rq_we[j])) w = j;
        end
        if (w < 0) begin
            @(posedge clk); #1;
            chk({tg, "_idle_en"}, 64'(s_en_o), 64'd0);
            chk({tg, "_idle_ack"}, 64'(m_ack_o), 64'd0);
            return;
        end
        m  = rq_mask[w];
        we = rq_we[w];
        us = rq_us[w];
        @(posedge clk); #1;
        obs_sen = s_en_o; obs_rw = s_rw_o; obs_smask = s_byte_mask_o; obs_swd = s_wdata_o;
        chk({tg, "_acc_en"}, 64'(s_en_o), 64'(legal_m(m)));
        chk({tg, "_acc_rw"}, 64'(s_rw_o), 64'(we));
        chk({tg, "_acc_addr"}, 64'(s_addr_o), 64'(rq_addr[w]));
        chk({tg, "_acc_mask"}, 64'(s_byte_mask_o), 64'(m));
        chk({tg, "_acc_wd"}, 64'(s_wdata_o), 64'(32'(64'(rq_wdata[w]) << (8 * low_lane(m)))));
        chk({tg, "_acc_ack"}, 64'(m_ack_o), 64'd0);
        sr = fix_rd ? fix_val : 32'($urandom);
        s_rdata = sr;
        if (raise_mid == -2) begin
            for (int i = 0; i < N; i++) if (!act[i] && $urandom_range(0, 2) == 0) rand_req(i);
        end else if (raise_mid >= 0 && !act[raise_mid]) begin
            set_req(raise_mid, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h3000, 32'h0);
        end
        @(posedge clk); #1;
        obs_ack = m_ack_o; obs_rd = m_rdata_o;
        chk({tg, "_resp_ack"}, 64'(m_ack_o), 64'd1 << w);
        chk({tg, "_resp_en"}, 64'(s_en_o), 64'd0);
        chk({tg, "_resp_rd"}, 64'(m_rdata_o), we ? 64'd0 : 64'(exp_rd(m, us, sr)));
        if (!reissue) act[w] = 1'b0;
        ptr_m = (w + 1) % N;
        @(posedge clk); #1;
        chk({tg, "_idle_ack"}, 64'(m_ack_o), 64'd0);
        chk({tg, "_idle_rd"}, 64'(m_rdata_o), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        s_rdata = '0;
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; rq_re[i] = 1'b0; rq_we[i] = 1'b0; rq_us[i] = 1'b0;
            rq_mask[i] = '0; rq_addr[i] = '0; rq_wdata[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", 64'(s_en_o), 64'd0);
        chk("rst_ack", 64'(m_ack_o), 64'd0);
        chk("rst_rd", 64'(m_rdata_o), 64'd0);
        chk("rst_wd", 64'(s_wdata_o), 64'd0);
        chk("rst_addr", 64'(s_addr_o), 64'd0);
        rst = 1'b0;

        // All four masters hold re continuously: grants rotate 0,1,2,3,0.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b1, 4'b1111, 32'h100 + 32'(i), 32'h0);
        for (int k = 0; k < 5; k++) begin
            txn("rr", 1'b1, -1);
            chk("rr_order", 64'(obs_ack), 64'd1 << (k % N));
        end
        for (int i = 0; i < N; i++) act[i] = 1'b0;

        // Byte read on lane 2, sign- then zero-extended.
        fix_rd = 1'b1; fix_val = 32'h0080_0000;
        set_req(1, 1'b1, 1'b0, 1'b0, 4'b0100, 32'h40, 32'h0);
        txn("byte_s", 1'b0, -1);
        chk("byte_sx", 64'(obs_rd), 64'hFFFF_FF80);
        set_req(1, 1'b1, 1'b0, 1'b1, 4'b0100, 32'h40, 32'h0);
        txn("byte_u", 1'b0, -1);
        chk("byte_zx", 64'(obs_rd), 64'h0000_0080);
        fix_rd = 1'b0;

        // Upper halfword write.
        set_req(2, 1'b0, 1'b1, 1'b0, 4'b1100, 32'h80, 32'h0000_BEEF);
        txn("hw_wr", 1'b0, -1);
        chk("hw_wdata", 64'(obs_swd), 64'hBEEF_0000);
        chk("hw_mask", 64'(obs_smask), 64'hC);
        chk("hw_rw", 64'(obs_rw), 64'd1);

        // Misaligned mask is refused but still acked.
        set_req(0, 1'b1, 1'b0, 1'b0, 4'b0110, 32'h90, 32'h0);
        txn("bad_mask", 1'b0, -1);
        chk("bad_en", 64'(obs_sen), 64'd0);
        chk("bad_ack", 64'(obs_ack), 64'd1);
        chk("bad_rd", 64'(obs_rd), 64'd0);

        // m3 raises re during m0's ACCESS; must wait for the next IDLE.
        set_req(0, 1'b1, 1'b0, 1'b1, 4'b1111, 32'hA0, 32'h0);
        txn("late_m0", 1'b0, 3);
        chk("late_ack0", 64'(obs_ack), 64'd1);
        txn("late_m3", 1'b0, -1);
        chk("late_ack3", 64'(obs_ack), 64'd8);

        // Reset mid-ACCESS aborts without ack and returns the pointer to m0.
        set_req(1, 1'b1, 1'b0, 1'b0, 4'b0001, 32'hB0, 32'h0);
        txn("pre_rst", 1'b0, -1);
        set_req(2, 1'b1, 1'b0, 1'b0, 4'b0001, 32'hC0, 32'h0);
        @(posedge clk); #1;
        chk("mid_acc_en", 64'(s_en_o), 64'd1);
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b0, 4'b0011, 32'hD0, 32'h0);
        set_req(3, 1'b1, 1'b0, 1'b0, 4'b0011, 32'hE0, 32'h0);
        @(posedge clk); #1;
        chk("abort_en", 64'(s_en_o), 64'd0);
        chk("abort_ack", 64'(m_ack_o), 64'd0);
        chk("abort_rd", 64'(m_rdata_o), 64'd0);
        rst = 1'b0;
        ptr_m = 0;
        txn("post_rst", 1'b0, -1);
        chk("post_rst_ack", 64'(obs_ack), 64'd1);
        for (int i = 0; i < N; i++) act[i] = 1'b0;

        // Randomized traffic.
        for (int it = 0; it < 200; it++) begin
            for (int i = 0; i < N; i++) if (!act[i] && $urandom_range(0, 1) == 0) rand_req(i);
            txn("rnd", 1'b0, -2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
